// File: rtl/int_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map, FSM encoding and
// the interrupt line / write-enable levels used across the peripheral set.
package int_ctrl_pkg;

  localparam int INT_ID_W = 8;

  localparam logic [3:0] INT_CTRL_ENABLE  = 4'h0;
  localparam logic [3:0] INT_CTRL_PENDING = 4'h4;
  localparam logic [3:0] INT_CTRL_MODE    = 4'h8;
  localparam logic [3:0] INT_CTRL_STATUS  = 4'hC;

  localparam logic INT_ASSERT   = 1'b1;
  localparam logic INT_DEASSERT = 1'b0;
  localparam logic WriteEnable  = 1'b1;

  typedef enum logic [1:0] {
    INT_IDLE = 2'd0,
    INT_REQ  = 2'd1,
    INT_BUSY = 2'd2
  } int_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  addr;
    logic [31:0] data;
  } bus_req_t;

endpackage

// File: rtl/int_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set bit of the eligible vector wins.
module int_ctrl_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0]  eligible,
  output logic                valid,
  output logic [INT_ID_W-1:0] id
);

  // Scan from the top down so the lowest index is written last.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        valid = 1'b1;
        id    = INT_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches/masks interrupt lines, raises one request at a time
// to the core with req/ack, completion by bus write. Optional input synchronizer: INT_CTRL_SYNC_EN.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         data_i,
  input  logic [31:0]         addr_i,
  input  logic                we_i,
  output logic [31:0]         data_o,
  input  logic [NUM_SRC-1:0]  int_i,
  output logic                int_req_o,
  output logic [INT_ID_W-1:0] int_id_o,
  input  logic                int_ack_i
);

  bus_req_t bus;
  assign bus = '{we: we_i, addr: addr_i[3:0], data: data_i};

  logic unused_bus;
  assign unused_bus = ^{addr_i[31:4], data_i};

  logic [NUM_SRC-1:0]  enable, mode, pending, pending_d, prev, src, eligible;
  logic [INT_ID_W-1:0] claimed_id, claimed_d, id_d, enc_id;
  logic                req_d, enc_vld, claim, w1c, cmpl_wr;
  int_state_e          state_q, state_d;

`ifdef INT_CTRL_SYNC_EN
  logic [NUM_SRC-1:0] sync1, sync2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= int_i;
      sync2 <= sync1;
    end
  end
  assign src = sync2;
`else
  assign src = int_i;
`endif

  assign w1c     = (bus.we == WriteEnable) && (bus.addr == INT_CTRL_PENDING);
  assign cmpl_wr = (bus.we == WriteEnable) && (bus.addr == INT_CTRL_STATUS);

  // Edge bits: set beats both the W1C and the claim clear.
  always_comb begin
    pending_d = pending;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!mode[i])
        pending_d[i] = src[i];
      else if (src[i] && !prev[i])
        pending_d[i] = INT_ASSERT;
      else if ((w1c && bus.data[i]) || (claim && int_id_o == INT_ID_W'(i)))
        pending_d[i] = INT_DEASSERT;
    end
  end

  assign eligible = pending & enable;

  int_ctrl_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .eligible (eligible),
    .valid    (enc_vld),
    .id       (enc_id)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = int_req_o;
    id_d      = int_id_o;
    claimed_d = claimed_id;
    claim     = 1'b0;
    case (state_q)
      INT_REQ: begin
        if (int_ack_i) begin
          state_d   = INT_BUSY;
          req_d     = INT_DEASSERT;
          claimed_d = int_id_o;
          claim     = 1'b1;
        end
      end
      INT_BUSY: begin
        if (cmpl_wr && bus.data[7:0] == claimed_id)
          state_d = INT_IDLE;
      end
      default: begin
        // The unused encoding behaves exactly like IDLE.
        if (enc_vld) begin
          state_d = INT_REQ;
          req_d   = INT_ASSERT;
          id_d    = enc_id;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= INT_IDLE;
      int_req_o  <= 1'b0;
      int_id_o   <= '0;
      claimed_id <= '0;
      enable     <= '0;
      mode       <= '0;
      pending    <= '0;
      prev       <= '0;
    end else begin
      state_q    <= state_d;
      int_req_o  <= req_d;
      int_id_o   <= id_d;
      claimed_id <= claimed_d;
      pending    <= pending_d;
      prev       <= src;
      if (bus.we == WriteEnable && bus.addr == INT_CTRL_ENABLE) enable <= bus.data[NUM_SRC-1:0];
      if (bus.we == WriteEnable && bus.addr == INT_CTRL_MODE)   mode   <= bus.data[NUM_SRC-1:0];
    end
  end

  logic [31:0] rd;
  always_comb begin
    rd = '0;
    case (bus.addr)
      INT_CTRL_ENABLE:  rd[NUM_SRC-1:0] = enable;
      INT_CTRL_PENDING: rd[NUM_SRC-1:0] = pending;
      INT_CTRL_MODE:    rd[NUM_SRC-1:0] = mode;
      INT_CTRL_STATUS:  rd = {22'b0, state_q, claimed_id};
      default:          rd = '0;
    endcase
  end

  assign data_o = rst ? 32'h0 : rd;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl; latency offsets follow INT_CTRL_SYNC_EN.
module tb_int_ctrl;

  localparam int NUM_SRC = 8;
`ifdef INT_CTRL_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [31:0]        data_i = '0;
  logic [31:0]        addr_i = '0;
  logic               we_i = 1'b0;
  logic [31:0]        data_o;
  logic [NUM_SRC-1:0] int_i = '0;
  logic               int_req_o;
  logic [7:0]         int_id_o;
  logic               int_ack_i = 1'b0;

  int tests = 0;
  int fails = 0;

  int_ctrl #(.NUM_SRC(NUM_SRC)) dut (
    .clk       (clk),
    .rst       (rst),
    .data_i    (data_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .data_o    (data_o),
    .int_i     (int_i),
    .int_req_o (int_req_o),
    .int_id_o  (int_id_o),
    .int_ack_i (int_ack_i)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    addr_i = {28'h0, a};
    data_i = d;
    we_i   = 1'b1;
    step();
    we_i   = 1'b0;
    data_i = '0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] v);
    addr_i = {28'h0, a};
    #1;
    v = data_o;
  endtask

  task automatic ack();
    int_ack_i = 1'b1;
    step();
    int_ack_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] v;
    step();
    step();
    tests++; if (int_req_o !== 1'b0) begin fails++; $display("FAIL rst_req: got %0b want 0", int_req_o); end
    tests++; if (int_id_o !== 8'h0) begin fails++; $display("FAIL rst_id: got %0h want 0", int_id_o); end
    tests++; if (data_o !== 32'h0) begin fails++; $display("FAIL rst_data_o: got %0h want 0", data_o); end
    rst = 1'b0;
    rd(4'hC, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_status: got %0h want 0", v); end
    rd(4'h0, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL rst_enable: got %0h want 0", v); end
  endtask

  task automatic test_level();
    logic [31:0] v;
    wr(4'h0, 32'h01);
    int_i[0] = 1'b1;
    repeat (SL) step();
    step();
    tests++; if (int_req_o !== 1'b0) begin fails++; $display("FAIL lvl_req_early: got %0b want 0", int_req_o); end
    rd(4'h4, v);
    tests++; if (v !== 32'h01) begin fails++; $display("FAIL lvl_pending: got %0h want 1", v); end
    step();
    tests++; if (int_req_o !== 1'b1 || int_id_o !== 8'd0) begin fails++; $display("FAIL lvl_req: got req=%0b id=%0d want req=1 id=0", int_req_o, int_id_o); end
    ack();
    tests++; if (int_req_o !== 1'b0) begin fails++; $display("FAIL lvl_ack_req: got %0b want 0", int_req_o); end
    rd(4'hC, v);
    tests++; if (v !== 32'h200) begin fails++; $display("FAIL lvl_status_busy: got %0h want 200", v); end
    step();
    tests++; if (int_req_o !== 1'b0) begin fails++; $display("FAIL lvl_busy_noreq: got %0b want 0", int_req_o); end
    wr(4'hC, 32'h0);
    rd(4'hC, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL lvl_status_idle: got %0h want 0", v); end
    tests++; if (int_req_o !== 1'b0) begin fails++; $display("FAIL lvl_cmpl_req: got %0b want 0", int_req_o); end
    step();
    tests++; if (int_req_o !== 1'b1) begin fails++; $display("FAIL lvl_rereq: got %0b want 1", int_req_o); end
    int_i = '0;
    ack();
    repeat (4) step();
    wr(4'hC, 32'h0);
  endtask

  task automatic test_priority();
    logic [31:0] v;
    wr(4'h0, 32'hFF);
    int_i[5] = 1'b1;
    repeat (SL) step();
    step();
    step();
    tests++; if (int_req_o !== 1'b1 || int_id_o !== 8'd5) begin fails++; $display("FAIL pri_req5: got req=%0b id=%0d want req=1 id=5", int_req_o, int_id_o); end
    int_i[2] = 1'b1;
    repeat (SL + 2) step();
    tests++; if (int_req_o !== 1'b1 || int_id_o !== 8'd5) begin fails++; $display("FAIL pri_freeze: got req=%0b id=%0d want req=1 id=5", int_req_o, int_id_o); end
    ack();
    rd(4'hC, v);
    tests++; if (v !== 32'h205) begin fails++; $display("FAIL pri_status: got %0h want 205", v); end
    tests++; if (int_id_o !== 8'd5) begin fails++; $display("FAIL pri_id_hold: got %0d want 5", int_id_o); end
    int_i[5] = 1'b0;
    repeat (4) step();
    wr(4'hC, 32'h5);
    step();
    tests++; if (int_req_o !== 1'b1 || int_id_o !== 8'd2) begin fails++; $display("FAIL pri_next: got req=%0b id=%0d want req=1 id=2", int_req_o, int_id_o); end
    int_i = '0;
    ack();
    repeat (4) step();
    wr(4'hC, 32'h2);
    rd(4'hC, v);
    tests++; if (v !== 32'h002) begin fails++; $display("FAIL pri_status_idle: got %0h want 2", v); end
  endtask

  task automatic test_edge_w1c();
    logic [31:0] v;
    wr(4'h0, 32'h00);
    wr(4'h8, 32'h08);
    int_i[3] = 1'b1;
    step();
    int_i[3] = 1'b0;
    repeat (SL + 1) step();
    rd(4'h4, v);
    tests++; if (v !== 32'h08) begin fails++; $display("FAIL edge_pending: got %0h want 8", v); end
    tests++; if (int_req_o !== 1'b0) begin fails++; $display("FAIL edge_noreq: got %0b want 0", int_req_o); end
    wr(4'h4, 32'h08);
    rd(4'h4, v);
    tests++; if (v !== 32'h00) begin fails++; $display("FAIL edge_w1c: got %0h want 0", v); end
    int_i[3] = 1'b1;
    step();
    int_i[3] = 1'b0;
    repeat (SL + 1) step();
    int_i[3] = 1'b1;
    repeat (SL) step();
    wr(4'h4, 32'h08);
    rd(4'h4, v);
    tests++; if (v !== 32'h08) begin fails++; $display("FAIL edge_set_beats_clr: got %0h want 8", v); end
    int_i = '0;
    wr(4'h8, 32'h00);
    repeat (SL + 2) step();
  endtask

  task automatic test_mask();
    logic [31:0] v;
    wr(4'h0, 32'h00);
    int_i[1] = 1'b1;
    repeat (SL + 1) step();
    rd(4'h4, v);
    tests++; if (v !== 32'h02) begin fails++; $display("FAIL mask_pending: got %0h want 2", v); end
    wr(4'h4, 32'h02);
    rd(4'h4, v);
    tests++; if (v !== 32'h02) begin fails++; $display("FAIL mask_level_w1c: got %0h want 2", v); end
    tests++; if (int_req_o !== 1'b0) begin fails++; $display("FAIL mask_noreq: got %0b want 0", int_req_o); end
    wr(4'h0, 32'h02);
    tests++; if (int_req_o !== 1'b0) begin fails++; $display("FAIL mask_req_early: got %0b want 0", int_req_o); end
    step();
    tests++; if (int_req_o !== 1'b1 || int_id_o !== 8'd1) begin fails++; $display("FAIL mask_req: got req=%0b id=%0d want req=1 id=1", int_req_o, int_id_o); end
    int_i = '0;
    ack();
    repeat (4) step();
    wr(4'hC, 32'h1);
  endtask

  task automatic test_wrong_complete();
    logic [31:0] v;
    wr(4'h8, 32'h10);
    wr(4'h0, 32'h10);
    int_i[4] = 1'b1;
    step();
    int_i[4] = 1'b0;
    repeat (SL) step();
    step();
    tests++; if (int_req_o !== 1'b1 || int_id_o !== 8'd4) begin fails++; $display("FAIL wc_req: got req=%0b id=%0d want req=1 id=4", int_req_o, int_id_o); end
    ack();
    rd(4'h4, v);
    tests++; if (v !== 32'h00) begin fails++; $display("FAIL wc_claim_clr: got %0h want 0", v); end
    wr(4'hC, 32'h3);
    rd(4'hC, v);
    tests++; if (v !== 32'h204) begin fails++; $display("FAIL wc_wrong_id: got %0h want 204", v); end
    wr(4'hC, 32'h4);
    rd(4'hC, v);
    tests++; if (v !== 32'h004) begin fails++; $display("FAIL wc_right_id: got %0h want 4", v); end
    step();
    tests++; if (int_req_o !== 1'b0) begin fails++; $display("FAIL wc_noreq: got %0b want 0", int_req_o); end
    wr(4'h8, 32'h00);
  endtask

  task automatic test_async_reset();
    logic [31:0] v;
    wr(4'h0, 32'h01);
    wr(4'h8, 32'h01);
    int_i[0] = 1'b1;
    repeat (SL) step();
    step();
    step();
    tests++; if (int_req_o !== 1'b1) begin fails++; $display("FAIL ar_req: got %0b want 1", int_req_o); end
    #2 rst = 1'b1;
    #1;
    tests++; if (int_req_o !== 1'b0) begin fails++; $display("FAIL ar_req_drop: got %0b want 0", int_req_o); end
    tests++; if (data_o !== 32'h0) begin fails++; $display("FAIL ar_data_o: got %0h want 0", data_o); end
    int_i = '0;
    step();
    rst = 1'b0;
    rd(4'h0, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL ar_enable: got %0h want 0", v); end
    rd(4'h8, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL ar_mode: got %0h want 0", v); end
    rd(4'h4, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL ar_pending: got %0h want 0", v); end
    rd(4'hC, v);
    tests++; if (v !== 32'h0) begin fails++; $display("FAIL ar_status: got %0h want 0", v); end
    step();
    tests++; if (int_req_o !== 1'b0 || int_id_o !== 8'd0) begin fails++; $display("FAIL ar_idle: got req=%0b id=%0d want req=0 id=0", int_req_o, int_id_o); end
  endtask

  initial begin
    test_reset();
    test_level();
    test_priority();
    test_edge_w1c();
    test_mask();
    test_wrong_complete();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
